// File: rtl/axil_gen_pkg.sv
// -----------------------------------------------------------------------------
// axil_gen_pkg
// Shared encodings for the AXI-Lite write traffic generator:
//   - FSM state encoding (WAIT / SEND / RESP)
//   - data pattern mode encoding (MODE_INC / MODE_WALK / MODE_CONST / MODE_INV)
//   - small helper for the saturating error counter
// No ports (package).
// -----------------------------------------------------------------------------
package axil_gen_pkg;

   // FSM states
   localparam logic [1:0] ST_WAIT = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Data pattern select, sampled when a transaction launches
   localparam logic [1:0] MODE_INC   = 2'd0;
   localparam logic [1:0] MODE_WALK  = 2'd1;
   localparam logic [1:0] MODE_CONST = 2'd2;
   localparam logic [1:0] MODE_INV   = 2'd3;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/axil_traffic_gen_if.sv
// -----------------------------------------------------------------------------
// axil_traffic_gen_if
// Write-only AXI-Lite bundle (AW, W, B channels) used by the traffic generator.
//   master modport : drives AWADDR/AWVALID, WDATA/WSTRB/WVALID, BREADY
//   slave  modport : drives AWREADY, WREADY, BRESP/BVALID
// Parameters: ADDR_WIDTH, DATA_WIDTH (multiple of 8).
// -----------------------------------------------------------------------------
interface axil_traffic_gen_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
   logic                    M_AXI_AWVALID;
   logic                    M_AXI_AWREADY;

   logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
   logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
   logic                    M_AXI_WVALID;
   logic                    M_AXI_WREADY;

   logic [1:0]              M_AXI_BRESP;
   logic                    M_AXI_BVALID;
   logic                    M_AXI_BREADY;

   modport master (
      output M_AXI_AWADDR, M_AXI_AWVALID,
      input  M_AXI_AWREADY,
      output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
      input  M_AXI_WREADY,
      input  M_AXI_BRESP, M_AXI_BVALID,
      output M_AXI_BREADY
   );

   modport slave (
      input  M_AXI_AWADDR, M_AXI_AWVALID,
      output M_AXI_AWREADY,
      input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
      output M_AXI_WREADY,
      output M_AXI_BRESP, M_AXI_BVALID,
      input  M_AXI_BREADY
   );

endinterface

// File: rtl/axil_pattern_gen.sv
// -----------------------------------------------------------------------------
// axil_pattern_gen
// Holds the write-data pattern state and selects the value for the next write.
//   clk, rst_n : clock, synchronous active-low reset
//   advance    : one pulse per completed write; steps increment and walking-one
//                state regardless of the mode currently selected
//   mode       : pattern select (MODE_INC / MODE_WALK / MODE_CONST / MODE_INV)
//   data       : pattern value for the selected mode (combinational from state
//                and mode; the top level registers it at launch)
// -----------------------------------------------------------------------------
module axil_pattern_gen
   import axil_gen_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] SEED       = 32'h00001230
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  advance,
   input  logic [1:0]            mode,
   output logic [DATA_WIDTH-1:0] data
);

   // SEED zero-extended or truncated to the data width
   localparam logic [DATA_WIDTH-1:0] SEED_D = DATA_WIDTH'(SEED);

   logic [DATA_WIDTH-1:0] inc_val;
   logic [DATA_WIDTH-1:0] walk_val;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inc_val  <= SEED_D;
         walk_val <= DATA_WIDTH'(1);
      end else if (advance) begin
         inc_val  <= inc_val + 1'b1;
         walk_val <= {walk_val[DATA_WIDTH-2:0], walk_val[DATA_WIDTH-1]};
      end
   end

   always_comb begin
      data = inc_val;
      case (mode)
         MODE_WALK:  data = walk_val;
         MODE_CONST: data = SEED_D;
         MODE_INV:   data = ~inc_val;
         default:    data = inc_val;
      endcase
   end

endmodule

// File: rtl/axil_traffic_gen.sv
// -----------------------------------------------------------------------------
// axil_traffic_gen
// AXI-Lite write traffic generator. After a programmable idle period it issues
// one write (AW + W together), waits for the B response, then moves to the next
// channel address and data pattern.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : permits new transactions (an in-flight write always finishes)
//   period     : idle cycles counted in WAIT before the next launch
//   mode       : data pattern select, sampled at launch
//   m_axi      : AXI-Lite write master (AW/W/B channels)
//   busy       : high whenever a write is in flight (state != WAIT)
//   wr_count   : completed writes, wraps at 2^32
//   err_count  : non-OKAY responses, saturates at 16'hFFFF
// Every output comes from a register or from registered state only; nothing
// is combinational from an input.
// -----------------------------------------------------------------------------
module axil_traffic_gen
   import axil_gen_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    NUM_CH      = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h40000004),
   parameter int unsigned           ADDR_STRIDE = 4,
   parameter logic [31:0]           SEED        = 32'h00001230,
   parameter int                    PERIOD_W    = 27
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [PERIOD_W-1:0] period,
   input  logic [1:0]          mode,
   axil_traffic_gen_if.master  m_axi,
   output logic                busy,
   output logic [31:0]         wr_count,
   output logic [15:0]         err_count
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

   logic [1:0]            state;
   logic [PERIOD_W-1:0]   dly_cnt;
   logic [CH_W-1:0]       ch;
   logic                  awvalid;
   logic                  wvalid;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] pat_data;
   logic [ADDR_WIDTH-1:0] ch_off;
   logic                  retire;
   logic                  aw_clear;
   logic                  w_clear;

   // A write retires in the RESP cycle where the slave presents BVALID
   assign retire = (state == ST_RESP) && m_axi.M_AXI_BVALID;

   // A channel is finished once its VALID is low or is being accepted now
   assign aw_clear = !awvalid || m_axi.M_AXI_AWREADY;
   assign w_clear  = !wvalid  || m_axi.M_AXI_WREADY;

   axil_pattern_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .SEED       (SEED)
   ) u_pat (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (retire),
      .mode    (mode),
      .data    (pat_data)
   );

   // Address follows ch, which only moves in RESP, so it is stable for the
   // whole time AWVALID is high.
   assign ch_off = ADDR_WIDTH'(ch) * ADDR_WIDTH'(ADDR_STRIDE);

   assign m_axi.M_AXI_AWADDR  = BASE_ADDR + ch_off;
   assign m_axi.M_AXI_AWVALID = awvalid;
   assign m_axi.M_AXI_WDATA   = wdata;
   assign m_axi.M_AXI_WSTRB   = '1;
   assign m_axi.M_AXI_WVALID  = wvalid;
   assign m_axi.M_AXI_BREADY  = (state == ST_RESP);

   assign busy = (state != ST_WAIT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_WAIT;
         dly_cnt   <= '0;
         ch        <= '0;
         awvalid   <= 1'b0;
         wvalid    <= 1'b0;
         wdata     <= '0;
         wr_count  <= '0;
         err_count <= '0;
      end else begin
         case (state)
            ST_WAIT: begin
               // Count up to period, then hold there until en allows a launch.
               // A counter above period (period lowered meanwhile) also launches.
               if (dly_cnt < period) begin
                  dly_cnt <= dly_cnt + 1'b1;
               end else if (en) begin
                  awvalid <= 1'b1;
                  wvalid  <= 1'b1;
                  wdata   <= pat_data;
                  state   <= ST_SEND;
               end
            end

            ST_SEND: begin
               if (awvalid && m_axi.M_AXI_AWREADY) awvalid <= 1'b0;
               if (wvalid && m_axi.M_AXI_WREADY)   wvalid  <= 1'b0;
               if (aw_clear && w_clear)            state   <= ST_RESP;
            end

            ST_RESP: begin
               if (m_axi.M_AXI_BVALID) begin
                  wr_count <= wr_count + 32'd1;
                  if (m_axi.M_AXI_BRESP != RESP_OKAY) err_count <= sat_inc16(err_count);
                  dly_cnt  <= '0;
                  ch       <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                  state    <= ST_WAIT;
               end
            end

            default: state <= ST_WAIT;
         endcase
      end
   end

endmodule

// File: doc/axil_traffic_gen.md
AXIL_TRAFFIC_GEN -- requirements
Module: axil_traffic_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_WIDTH, 32, AXI-Lite address width.
REQ-002 DATA_WIDTH, 32, data width (multiple of 8); NUM_CH, 4, number of target registers (1..256).
REQ-003 BASE_ADDR, 32'h40000004, channel-0 address; ADDR_STRIDE, 4, byte step between channels.
REQ-004 SEED, 32'h00001230, initial data value (zero-extended or truncated to DATA_WIDTH); PERIOD_W, 27, width of the period input.
REQ-005 SHALL have ports (name, direction, width, meaning): clk, in, 1, sole clock.
REQ-006 rst_n, in, 1, reset: one clock, synchronous, active-low.
REQ-007 en, in, 1, allows new transactions; period, in, PERIOD_W, idle cycles between transactions; mode, in, 2, data pattern select.
REQ-008 M_AXI_AWADDR out ADDR_WIDTH; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
REQ-009 M_AXI_WDATA out DATA_WIDTH; M_AXI_WSTRB out DATA_WIDTH/8; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
REQ-010 M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
REQ-011 busy out 1 (state != WAIT); wr_count out 32, completed writes; err_count out 16, non-OKAY responses.

Function
REQ-012 SHALL use states WAIT, SEND, RESP.
REQ-013 WAIT: delay counter increments each cycle while below period; when counter == period and en=1, SHALL assert AWVALID and WVALID together next cycle and enter SEND; when en=0, counter holds at period.
REQ-014 period=0: launch SHALL occur on the first WAIT cycle with en=1.
REQ-015 SEND: AW and W SHALL handshake independently; each VALID drops the cycle after its own READY; both READY in the same cycle is legal; enter RESP once both handshakes have completed.
REQ-016 AWADDR, WDATA, WSTRB SHALL remain stable while the respective VALID is high; WSTRB is all-ones.
REQ-017 RESP: BREADY=1; on BVALID, drop BREADY, increment wr_count (wraps at 2^32), increment err_count if BRESP!=2'b00 (saturates at 16'hFFFF), clear delay counter, advance channel and pattern, return to WAIT.
REQ-018 Address SHALL be BASE_ADDR + ch*ADDR_STRIDE, modulo 2^ADDR_WIDTH; ch runs 0..NUM_CH-1 round-robin, wrapping to 0 after NUM_CH-1.
REQ-019 mode SHALL be sampled at launch: 0 = increment (value starts at SEED, +1 per completed write, wraps); 1 = walking-one (starts at bit 0, rotates left, bit DATA_WIDTH-1 wraps to bit 0); 2 = constant SEED; 3 = bitwise inverse of the increment value.
REQ-020 Increment and walking-one state SHALL advance on every completed write, independent of the mode in use.
REQ-021 en deasserted in SEND/RESP SHALL NOT abort the transaction; it completes, then the block holds in WAIT.
REQ-022 VALID SHALL never be asserted combinationally from READY; no output depends combinationally on any input.

Reset
REQ-023 On clk edge with rst_n=0: state=WAIT; counters, ch, wr_count, err_count = 0; increment value = SEED; walking-one value = 1.
REQ-024 Reset outputs: AWVALID, WVALID, BREADY, busy = 0; AWADDR=BASE_ADDR; WDATA=0; WSTRB all-ones.
REQ-025 Reset during SEND/RESP SHALL drop all VALID/READY in that cycle; no partial transaction is resumed.

Structure
REQ-026 Shared package axil_gen_pkg SHALL hold the state encoding and the mode encodings (MODE_INC, MODE_WALK, MODE_CONST, MODE_INV).
REQ-027 Pattern values SHALL live in sub-module axil_pattern_gen (inputs: advance, mode; output: data); the FSM and channel logic stay in the top level.

Verification
REQ-028 period=3, en=1, mode=0, slave always ready, BRESP=0 -> AWADDR 0x40000004, 0x40000008, 0x4000000C, 0x40000010, 0x40000004; WDATA 0x1230..0x1234; wr_count=5.
REQ-029 AWREADY delayed 4 cycles, WREADY immediate -> WVALID drops after 1 cycle; AWVALID held with stable address; single BREADY pulse; one write counted.
REQ-030 mode=1, DATA_WIDTH=8, 9 writes -> WDATA 0x01,0x02,...,0x80,0x01.
REQ-031 BRESP=2'b10 on every 2nd write over 6 writes -> err_count=3, wr_count=6; err_count preset near saturation stays 16'hFFFF.
REQ-032 en dropped during SEND -> transaction completes, no further AWVALID until en=1; rst_n=0 during RESP -> BREADY=0 next cycle, state WAIT, counters 0.
